// File: rtl/alib_points_pkg.sv
// Shared definitions for the point FIFO read path: point widths, x/y/z packing
// order (x in [47:32], y in [31:16], z in [15:0]) and reader state encodings.
package alib_points_pkg;

   localparam int POINT_W      = 16;
   localparam int POINT_PACK_W = 48;

   typedef struct packed {
      logic [POINT_W-1:0] x;
      logic [POINT_W-1:0] y;
      logic [POINT_W-1:0] z;
   } point_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/alib_points_out_buffer.sv
// Two-entry registered valid/ready buffer; the reader's credit logic keeps it
// from ever being written while full, so there is no input-side ready.
module alib_points_out_buffer
   import alib_points_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [POINT_PACK_W-1:0] in_data,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [POINT_PACK_W-1:0] out_data,
   output logic [1:0]              occupancy
);

   logic [POINT_PACK_W-1:0] mem [2];
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              count;
   logic                    pop;

   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign occupancy = count;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (in_valid) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({in_valid, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alib_points_fifo_reader.sv
// Frame drain engine for the 48-bit point FIFO with a valid/ready output stream.
// Optional bounding-box accumulation is built when ALIB_POINTS_READER_BBOX_EN is defined.
module alib_points_fifo_reader
   import alib_points_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   frame_len,
   input  logic               fifo_empty,
   input  logic [POINT_W-1:0] fifo_point_x,
   input  logic [POINT_W-1:0] fifo_point_y,
   input  logic [POINT_W-1:0] fifo_point_z,
   output logic               fifo_rd_en,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [POINT_W-1:0] m_point_x,
   output logic [POINT_W-1:0] m_point_y,
   output logic [POINT_W-1:0] m_point_z,
   output logic               m_last,
   output logic               busy,
   output logic               done,
   output logic [POINT_W-1:0] bb_min_x,
   output logic [POINT_W-1:0] bb_min_y,
   output logic [POINT_W-1:0] bb_min_z,
   output logic [POINT_W-1:0] bb_max_x,
   output logic [POINT_W-1:0] bb_max_y,
   output logic [POINT_W-1:0] bb_max_z
);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] len_reg;
   logic [CNT_W-1:0] issued_cnt;
   logic [CNT_W-1:0] accepted_cnt;
   logic             in_flight;
   logic             start_acc;
   logic             pop;
   logic [1:0]       occupancy;
   logic [2:0]       credit_used;
   point_t           fifo_pt;
   point_t           head_pt;

   assign start_acc = (state == ST_IDLE) & start;
   assign fifo_pt   = '{x: fifo_point_x, y: fifo_point_y, z: fifo_point_z};
   assign pop       = m_valid & m_ready;

   // A beat leaving this cycle frees its slot, so sustained 1/cycle is possible.
   assign credit_used = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, pop};
   assign fifo_rd_en  = (state == ST_RUN) & ~fifo_empty & (issued_cnt < len_reg)
                        & (credit_used < 3'd2);

   alib_points_out_buffer u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_flight),
      .in_data   (fifo_pt),
      .out_ready (m_ready),
      .out_valid (m_valid),
      .out_data  (head_pt),
      .occupancy (occupancy)
   );

   assign m_point_x = head_pt.x;
   assign m_point_y = head_pt.y;
   assign m_point_z = head_pt.z;
   assign m_last    = m_valid & (accepted_cnt == len_reg - CNT_W'(1));
   assign busy      = (state == ST_RUN) | (state == ST_FLUSH);
   assign done      = (state == ST_DONE);

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = (frame_len == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (fifo_rd_en && (issued_cnt + CNT_W'(1) == len_reg)) state_next = ST_FLUSH;
         ST_FLUSH: if (pop && m_last) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Reset drops any read in flight; the FIFO recovers its own pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         len_reg      <= '0;
         issued_cnt   <= '0;
         accepted_cnt <= '0;
         in_flight    <= 1'b0;
      end else begin
         state     <= state_next;
         in_flight <= fifo_rd_en;
         if (start_acc) begin
            len_reg      <= frame_len;
            issued_cnt   <= '0;
            accepted_cnt <= '0;
         end else begin
            if (fifo_rd_en) issued_cnt <= issued_cnt + CNT_W'(1);
            if (pop) accepted_cnt <= accepted_cnt + CNT_W'(1);
         end
      end
   end

`ifdef ALIB_POINTS_READER_BBOX_EN
   point_t bb_min;
   point_t bb_max;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bb_min <= '0;
         bb_max <= '0;
      end else if (start_acc) begin
         bb_min <= '{x: '1, y: '1, z: '1};
         bb_max <= '0;
      end else if (pop) begin
         if (head_pt.x < bb_min.x) bb_min.x <= head_pt.x;
         if (head_pt.y < bb_min.y) bb_min.y <= head_pt.y;
         if (head_pt.z < bb_min.z) bb_min.z <= head_pt.z;
         if (head_pt.x > bb_max.x) bb_max.x <= head_pt.x;
         if (head_pt.y > bb_max.y) bb_max.y <= head_pt.y;
         if (head_pt.z > bb_max.z) bb_max.z <= head_pt.z;
      end
   end

   assign bb_min_x = bb_min.x;
   assign bb_min_y = bb_min.y;
   assign bb_min_z = bb_min.z;
   assign bb_max_x = bb_max.x;
   assign bb_max_y = bb_max.y;
   assign bb_max_z = bb_max.z;
`else
   assign bb_min_x = '0;
   assign bb_min_y = '0;
   assign bb_min_z = '0;
   assign bb_max_x = '0;
   assign bb_max_y = '0;
   assign bb_max_z = '0;
`endif

endmodule

// File: doc/alib_points_fifo_reader.md
# alib_points_fifo_reader

Frame-oriented drain engine on the read side of the 48-bit point FIFO. Pops a programmed number of 16-bit (x,y,z) points, hides the FIFO's one-cycle read latency behind a 2-entry output buffer, and presents them on a valid/ready stream with a last-point marker to the octree builder. Optionally accumulates the frame's axis-aligned bounding box for octree root sizing.

## Interface
- `CNT_W`, default 16: width of the frame length and point counters.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; accepted only in IDLE, ignored otherwise.
- `frame_len`  in  CNT_W  number of points to drain; sampled on an accepted `start`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_point_x`, `fifo_point_y`, `fifo_point_z`  in  16 each  FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO pop request.
- `m_valid`  out  1  stream point valid.
- `m_ready`  in  1  downstream accept.
- `m_point_x`, `m_point_y`, `m_point_z`  out  16 each  stream point.
- `m_last`  out  1  marks the final point of the frame; qualified by `m_valid`.
- `busy`  out  1  high in RUN and FLUSH.
- `done`  out  1  one-cycle pulse at frame completion.
- `bb_min_x`/`_y`/`_z`, `bb_max_x`/`_y`/`_z`  out  16 each  frame bounding box.

## Operation
- States:
  - IDLE: accepted `start` with `frame_len`≠0 → RUN; with `frame_len`=0 → DONE.
  - RUN → FLUSH when the issued count reaches `frame_len`.
  - FLUSH → DONE when the outstanding read has landed and the buffer is empty.
  - DONE → IDLE unconditionally, after one cycle.
- `fifo_rd_en` = RUN & !`fifo_empty` & (issued < `frame_len`) & (occupancy + in-flight < 2). It is never asserted while `fifo_empty` is high.
- Read data is written into the 2-entry buffer the cycle after `fifo_rd_en`. Credit accounting guarantees the buffer never overflows, so no read data is ever dropped.
- The stream handshake completes on `m_valid & m_ready`. Points leave in FIFO order, and `m_point_*` is held stable while `m_valid & !m_ready`.
- `m_last` is high when the buffer head is point index `frame_len`−1 (accepted count = `frame_len`−1).
- Counters are unsigned and CNT_W wide: an issued counter and an accepted counter, both cleared on an accepted `start`.
- A `start` pulse in any state other than IDLE is ignored.
- Reset, including mid-frame: state returns to IDLE and the buffer and counters clear. Any FIFO read already in flight is discarded. Recovering the FIFO's own state is the FIFO's reset responsibility.

## Timing
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0, all `m_point_*`=0, all `bb_*`=0.
- Accepted `start` at cycle 0:
  - `busy` is high from cycle 1.
  - The earliest `fifo_rd_en` is cycle 1.
  - The earliest `m_valid` is cycle 3.
- Throughput: 1 point/cycle sustained while `m_ready`=1 and the FIFO is non-empty.
- `done` pulses the cycle after the `m_last` handshake, in the DONE state; `busy` is low in that cycle.
- For `frame_len`=0: `done` at cycle 1, no FIFO reads, and `busy` never goes high.
- `m_valid` and `m_point_*` are driven from registers; there is no combinational path from `m_ready` to `m_valid`.

## Configuration
- `ALIB_POINTS_READER_BBOX_EN`
  - Defined: on an accepted `start`, each `bb_min_*` is set to 16'hFFFF and each `bb_max_*` to 16'h0000. Every stream handshake performs an unsigned min/max update per axis. Final values are stable from the `done` cycle until the next accepted `start`.
  - Undefined: all `bb_*` are tied to 0 and no comparator logic is built.

## Structure
- Shared package `alib_points_pkg` holds:
  - `POINT_W`=16 and `POINT_PACK_W`=48.
  - The x/y/z packing order: x in bits [47:32], y in [31:16], z in [15:0].
  - The reader state encodings IDLE/RUN/FLUSH/DONE.
- One sub-module, `alib_points_out_buffer`: a 2-entry 48-bit valid/ready buffer exposing its occupancy.
- The FSM, counters and optional bounding-box logic live in the top module.

## Test plan
- **Basic frame:** FIFO preloaded with points (1,2,3), (4,5,6), (7,8,9); `frame_len`=3; `m_ready`=1.
  - Three beats in order, `m_last` on (7,8,9) only.
  - `done` pulses one cycle after the last handshake; exactly 3 `fifo_rd_en` pulses.
- **Backpressure:** `frame_len`=8 with `m_ready` toggled 1,0,0,1 repeating.
  - No point lost or duplicated, data stable while stalled.
  - `fifo_rd_en` never raises occupancy above 2.
- **Starvation:** FIFO empty for 10 cycles after `start`, then 4 points written with `frame_len`=4.
  - `fifo_rd_en` stays low while empty.
  - Frame completes with the correct order; `busy` is high throughout.
- **Zero length and restart:** `frame_len`=0 gives `done` at cycle 1 with no reads. A `start` pulsed during RUN is ignored and `frame_len` is not re-sampled.
- **Mid-frame reset:** assert `rst` low after 2 of 5 points. All outputs return to their reset values immediately, and a fresh `start` runs normally.
- **Bounding box (macro defined):** points (5,100,7), (300,2,7), (9,50,65535).
  - min = (5,2,7), max = (300,100,65535) at `done`.
  - With the macro undefined, all `bb_*` = 0.
